// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES types and the FIPS-197 forward/inverse S-box tables
package aes_pkg;

  typedef enum logic {
    CIPH_FWD = 1'b0,
    CIPH_INV = 1'b1
  } cipher_op_e;

  // Indexed [row][column][bit]
  typedef logic [3:0][3:0][7:0] state_t;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

endpackage

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - single-byte AES S-box lookup, forward or inverse selected by op_i
module aes_sbox
  import aes_pkg::*;
(
  input  logic       op_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

  always_comb begin
    data_o = SBOX_FWD[data_i];
    if (op_i == CIPH_INV) begin
      data_o = SBOX_INV[data_i];
    end
  end

endmodule

// File: rtl/aes_subbytes.sv
// rtl/aes_subbytes.sv - combinational SubBytes/InvSubBytes over the 4x4 AES state
module aes_subbytes
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 op_i,
  input  logic [3:0][3:0][7:0] data_i,
  output logic [3:0][3:0][7:0] data_o
);

  // Clock and reset exist only so every round stage shares one port shape.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst;

  for (genvar r = 0; r < 4; r++) begin : g_row
    for (genvar c = 0; c < 4; c++) begin : g_col
      aes_sbox u_sbox (
        .op_i   (op_i),
        .data_i (data_i[r][c]),
        .data_o (data_o[r][c])
      );
    end
  end

endmodule

// File: tb/tb_aes_subbytes.sv
// tb/tb_aes_subbytes.sv - self-checking bench for aes_subbytes
module tb_aes_subbytes;
  import aes_pkg::*;

  typedef struct {
    logic   op;
    state_t din;
    state_t exp;
    string  name;
  } vec_t;

  logic   clk = 1'b0;
  logic   rst;
  logic   op_i;
  state_t data_i;
  state_t data_o;

  int errors = 0;
  int checks = 0;

  state_t exp_q[$];
  string  name_q[$];
  vec_t   vecs[$];

  logic [7:0] mdl_fwd [256];
  logic [7:0] mdl_inv [256];

  always #5 clk = ~clk;

  aes_subbytes dut (
    .clk    (clk),
    .rst    (rst),
    .op_i   (op_i),
    .data_i (data_i),
    .data_o (data_o)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
      b = {1'b0, b[7:1]};
    end
    return p;
  endfunction

  // Reference S-box from GF(2^8) inversion plus the affine map
  function automatic logic [7:0] gf_sbox(input logic [7:0] x);
    logic [7:0] inv, s;
    inv = 8'h00;
    if (x != 8'h00) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
    end
    s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
        ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    return s;
  endfunction

  function automatic state_t fill(input logic [7:0] b);
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = b;
    return s;
  endfunction

  function automatic state_t model(input logic op, input state_t d);
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = op ? mdl_inv[d[r][c]] : mdl_fwd[d[r][c]];
    return s;
  endfunction

  function automatic state_t rand_state();
    state_t s;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = 8'($urandom_range(0, 255));
    return s;
  endfunction

  task automatic check_out();
    state_t e;
    string  nm;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h required a queued expectation", data_o);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (data_o !== e) begin
        errors++;
        $display("FAIL %s: got %h required %h", nm, data_o, e);
      end
    end
  endtask

  task automatic apply(input logic op, input state_t d, input state_t e, input string nm);
    @(posedge clk);
    #1;
    op_i   = op;
    data_i = d;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(negedge clk);
    check_out();
  endtask

  function automatic vec_t mk(input logic op, input state_t d, input state_t e, input string nm);
    vec_t v;
    v.op = op; v.din = d; v.exp = e; v.name = nm;
    return v;
  endfunction

  initial begin
    state_t s, x;
    state_t fwd_out;

    for (int i = 0; i < 256; i++) mdl_fwd[i] = gf_sbox(8'(i));
    for (int i = 0; i < 256; i++) mdl_inv[mdl_fwd[i]] = 8'(i);

    vecs.push_back(mk(1'b0, fill(8'h00), fill(8'h63), "fwd_00"));
    vecs.push_back(mk(1'b0, fill(8'h01), fill(8'h7c), "fwd_01"));
    vecs.push_back(mk(1'b0, fill(8'hff), fill(8'h16), "fwd_ff"));
    vecs.push_back(mk(1'b0, fill(8'h4c), fill(8'h29), "fwd_4c"));
    s = fill(8'h00); x = fill(8'h63);
    s[0] = {4{8'ha5}};                      x[0] = {4{8'h06}};
    s[2] = {4{8'h01}};                      x[2] = {4{8'h7c}};
    s[3][0] = 8'hf0; s[3][1] = 8'hb0; s[3][2] = 8'h70; s[3][3] = 8'h30;
    x[3][0] = 8'h8c; x[3][1] = 8'he7; x[3][2] = 8'h51; x[3][3] = 8'h04;
    vecs.push_back(mk(1'b0, s, x, "fwd_mixed"));
    vecs.push_back(mk(1'b1, fill(8'h63), fill(8'h00), "inv_63"));
    vecs.push_back(mk(1'b1, fill(8'h00), fill(8'h52), "inv_00"));
    vecs.push_back(mk(1'b1, fill(8'h69), fill(8'he4), "inv_69"));
    vecs.push_back(mk(1'b1, fill(8'hbf), fill(8'hf4), "inv_bf"));
    vecs.push_back(mk(1'b1, fill(8'h16), fill(8'hff), "inv_16"));

    // Reset held low from time zero: output is still the S-box function
    rst    = 1'b0;
    op_i   = 1'b0;
    data_i = fill(8'h00);
    apply(1'b0, fill(8'h00), fill(8'h63), "reset_state");
    rst = 1'b1;

    foreach (vecs[i]) apply(vecs[i].op, vecs[i].din, vecs[i].exp, vecs[i].name);

    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) s[r][c] = 8'((r * 4 + c) * 17 + 5);
    apply(1'b0, s, model(1'b0, s), "position_fwd");
    apply(1'b1, s, model(1'b1, s), "position_inv");

    for (int v = 0; v < 256; v++) begin
      apply(1'b0, fill(8'(v)), fill(mdl_fwd[v]), "roundtrip_fwd");
      fwd_out = data_o;
      apply(1'b1, fwd_out, fill(8'(v)), "roundtrip_inv");
    end

    // Inputs change every cycle; any registered stage would lag by one
    for (int i = 0; i < 29; i++) begin
      s = rand_state();
      apply(i >= 15, s, model(i >= 15, s), "per_cycle");
    end

    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      s = rand_state();
      apply(i[0], s, model(i[0], s), "reset_held");
    end
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s = rand_state();
      apply(i[0], s, model(i[0], s), "reset_released");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
